// File: rtl/spi_data_path.sv
// SPI data path: TX/RX FIFOs with frame-length bit-order normalisation and watermark IRQs.
// Optional receive sign extension is built only when SPI_DATA_RX_SEXT_EN is defined.

module spi_data_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int PW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wen,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [PW-1:0]         level,
  output logic [PW-1:0]         level_next,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf,
  output logic                  udf
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign full  = (level == PW'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign rdata = empty ? '0 : mem[rd_ptr];

  // A write into a full FIFO is only accepted when a real read frees the slot.
  always_comb begin
    do_rd      = ren && !empty;
    do_wr      = wen && (!full || do_rd);
    level_next = clear ? '0 : level + PW'(do_wr) - PW'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
      if (wen && full && !ren) ovf <= 1'b1;
      if (ren && empty)        udf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clear && do_wr) mem[wr_ptr] <= wdata;
  end
endmodule

module spi_data_path #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int LW         = $clog2(DATA_WIDTH),
  parameter int PW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LW-1:0]         datalen,
  input  logic                  dord,
  input  logic                  rx_sext,
  input  logic [DATA_WIDTH-1:0] tx_wdata,
  input  logic                  tx_wen,
  input  logic                  tx_ren,
  output logic [DATA_WIDTH-1:0] tx_rdata,
  input  logic [DATA_WIDTH-1:0] rx_wdata,
  input  logic                  rx_wen,
  input  logic                  rx_ren,
  output logic [DATA_WIDTH-1:0] rx_rdata,
  input  logic                  tx_clear,
  input  logic                  rx_clear,
  input  logic [PW-1:0]         tx_thresh,
  input  logic [PW-1:0]         rx_thresh,
  output logic [PW-1:0]         tx_level,
  output logic [PW-1:0]         rx_level,
  output logic                  tx_full,
  output logic                  tx_empty,
  output logic                  rx_full,
  output logic                  rx_empty,
  output logic                  tx_irq,
  output logic                  rx_irq,
  output logic                  tx_ovf,
  output logic                  rx_ovf,
  output logic                  tx_udf,
  output logic                  rx_udf
);
  logic [DATA_WIDTH-1:0] tx_stored;
  logic [DATA_WIDTH-1:0] rx_head;
  logic [DATA_WIDTH-1:0] rx_norm;
  logic [PW-1:0]         tx_level_next;
  logic [PW-1:0]         rx_level_next;

  // Keeps bits [len:0] (reversed within the field when LSB-first), zeroes the rest.
  function automatic logic [DATA_WIDTH-1:0] normalise(input logic [DATA_WIDTH-1:0] d,
                                                       input logic [LW-1:0] len,
                                                       input logic msb_first);
    logic [DATA_WIDTH-1:0] r;
    logic [LW-1:0]         idx;
    r = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      idx = len - LW'(i);
      if (i <= int'(len) && (int'(len) - i) < DATA_WIDTH)
        r[i] = msb_first ? d[i] : d[idx];
    end
    return r;
  endfunction

  assign tx_stored = normalise(tx_wdata, datalen, dord);
  assign rx_norm   = normalise(rx_head, datalen, dord);

`ifdef SPI_DATA_RX_SEXT_EN
  logic rx_sign;
  assign rx_sign = rx_norm[datalen];

  always_comb begin
    rx_rdata = rx_norm;
    if (rx_sext) begin
      for (int i = 0; i < DATA_WIDTH; i++)
        if (i > int'(datalen)) rx_rdata[i] = rx_sign;
    end
  end
`else
  logic unused_rx_sext;
  assign unused_rx_sext = rx_sext;
  assign rx_rdata       = rx_norm;
`endif

  spi_data_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .PW(PW)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .clear(tx_clear), .wdata(tx_stored), .wen(tx_wen),
    .ren(tx_ren), .rdata(tx_rdata), .level(tx_level), .level_next(tx_level_next),
    .full(tx_full), .empty(tx_empty), .ovf(tx_ovf), .udf(tx_udf)
  );

  spi_data_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .PW(PW)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .clear(rx_clear), .wdata(rx_wdata), .wen(rx_wen),
    .ren(rx_ren), .rdata(rx_head), .level(rx_level), .level_next(rx_level_next),
    .full(rx_full), .empty(rx_empty), .ovf(rx_ovf), .udf(rx_udf)
  );

  // IRQs follow the next-state level so they move in the same cycle as the level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_irq <= 1'b0;
      rx_irq <= 1'b0;
    end else begin
      tx_irq <= (tx_level_next <= tx_thresh);
      rx_irq <= (rx_level_next >= rx_thresh) && (rx_thresh != '0);
    end
  end
endmodule

// File: tb/tb_spi_data_path.sv
// Directed self-checking bench for spi_data_path (32-bit, 8-deep); the sign-extension
// expectation follows SPI_DATA_RX_SEXT_EN.

module tb_spi_data_path;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  datalen;
  logic        dord, rx_sext;
  logic [31:0] tx_wdata, rx_wdata;
  logic        tx_wen, tx_ren, rx_wen, rx_ren, tx_clear, rx_clear;
  logic [3:0]  tx_thresh, rx_thresh;
  logic [31:0] tx_rdata, rx_rdata;
  logic [3:0]  tx_level, rx_level;
  logic        tx_full, tx_empty, rx_full, rx_empty, tx_irq, rx_irq;
  logic        tx_ovf, rx_ovf, tx_udf, rx_udf;

  int n_cmp = 0;
  int n_err = 0;

  spi_data_path #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .datalen(datalen), .dord(dord), .rx_sext(rx_sext),
    .tx_wdata(tx_wdata), .tx_wen(tx_wen), .tx_ren(tx_ren), .tx_rdata(tx_rdata),
    .rx_wdata(rx_wdata), .rx_wen(rx_wen), .rx_ren(rx_ren), .rx_rdata(rx_rdata),
    .tx_clear(tx_clear), .rx_clear(rx_clear), .tx_thresh(tx_thresh), .rx_thresh(rx_thresh),
    .tx_level(tx_level), .rx_level(rx_level), .tx_full(tx_full), .tx_empty(tx_empty),
    .rx_full(rx_full), .rx_empty(rx_empty), .tx_irq(tx_irq), .rx_irq(rx_irq),
    .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .tx_udf(tx_udf), .rx_udf(rx_udf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (tx_level !== 4'd0) begin n_err++; $display("[TB] FAIL reset_tx_level: got %0d expected 0", tx_level); end
    n_cmp++; if (rx_level !== 4'd0) begin n_err++; $display("[TB] FAIL reset_rx_level: got %0d expected 0", rx_level); end
    n_cmp++; if ({tx_empty, rx_empty, tx_full, rx_full} !== 4'b1100) begin n_err++; $display("[TB] FAIL reset_status: got %b expected 1100", {tx_empty, rx_empty, tx_full, rx_full}); end
    n_cmp++; if ({tx_irq, rx_irq} !== 2'b00) begin n_err++; $display("[TB] FAIL reset_irq: got %b expected 00", {tx_irq, rx_irq}); end
    n_cmp++; if ({tx_ovf, rx_ovf, tx_udf, rx_udf} !== 4'b0000) begin n_err++; $display("[TB] FAIL reset_flags: got %b expected 0000", {tx_ovf, rx_ovf, tx_udf, rx_udf}); end
    n_cmp++; if ({tx_rdata, rx_rdata} !== 64'd0) begin n_err++; $display("[TB] FAIL reset_rdata: got %h expected 0", {tx_rdata, rx_rdata}); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if ({tx_irq, rx_irq} !== 2'b10) begin n_err++; $display("[TB] FAIL release_irq: got %b expected 10", {tx_irq, rx_irq}); end
  endtask

  task automatic test_tx_norm();
    datalen = 5'd7; dord = 1'b0;
    tx_wdata = 32'h0000_01B1; tx_wen = 1'b1;
    tick();
    tx_wen = 1'b0;
    n_cmp++; if (tx_rdata !== 32'h0000_008D) begin n_err++; $display("[TB] FAIL tx_lsb_first: got %h expected 0000008d", tx_rdata); end
    n_cmp++; if (tx_level !== 4'd1) begin n_err++; $display("[TB] FAIL tx_level_one: got %0d expected 1", tx_level); end
    dord = 1'b1; tx_wen = 1'b1; tx_ren = 1'b1;
    tick();
    tx_wen = 1'b0; tx_ren = 1'b0;
    n_cmp++; if (tx_rdata !== 32'h0000_00B1) begin n_err++; $display("[TB] FAIL tx_msb_first: got %h expected 000000b1", tx_rdata); end
    n_cmp++; if (tx_level !== 4'd1) begin n_err++; $display("[TB] FAIL tx_rw_level: got %0d expected 1", tx_level); end
    tx_ren = 1'b1;
    tick();
    tx_ren = 1'b0;
    n_cmp++; if ({tx_empty, tx_udf} !== 2'b10 || tx_rdata !== 32'd0) begin n_err++; $display("[TB] FAIL tx_drain: got empty/udf %b data %h expected 10 / 0", {tx_empty, tx_udf}, tx_rdata); end
  endtask

  task automatic test_rx_norm();
    datalen = 5'd7; dord = 1'b1;
    rx_wdata = 32'h0000_00C5; rx_wen = 1'b1;
    tick();
    rx_wen = 1'b0;
    n_cmp++; if (rx_rdata !== 32'h0000_00C5) begin n_err++; $display("[TB] FAIL rx_msb_first: got %h expected 000000c5", rx_rdata); end
    dord = 1'b0;
    #1;
    n_cmp++; if (rx_rdata !== 32'h0000_00A3) begin n_err++; $display("[TB] FAIL rx_lsb_first: got %h expected 000000a3", rx_rdata); end
    dord = 1'b1; rx_sext = 1'b1;
    #1;
`ifdef SPI_DATA_RX_SEXT_EN
    n_cmp++; if (rx_rdata !== 32'hFFFF_FFC5) begin n_err++; $display("[TB] FAIL rx_sext: got %h expected ffffffc5", rx_rdata); end
`else
    n_cmp++; if (rx_rdata !== 32'h0000_00C5) begin n_err++; $display("[TB] FAIL rx_sext_off: got %h expected 000000c5", rx_rdata); end
`endif
    rx_sext = 1'b0; rx_ren = 1'b1;
    tick();
    rx_ren = 1'b0;
    n_cmp++; if ({rx_empty, rx_level} !== 5'b1_0000) begin n_err++; $display("[TB] FAIL rx_drain: got %b expected 10000", {rx_empty, rx_level}); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] exp;
    datalen = 5'd31; dord = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tx_wdata = 32'h100 + k; tx_wen = 1'b1;
      tick();
    end
    tx_wen = 1'b0;
    n_cmp++; if ({tx_full, tx_ovf, tx_irq} !== 3'b110) begin n_err++; $display("[TB] FAIL tx_full_flags: got %b expected 110", {tx_full, tx_ovf, tx_irq}); end
    n_cmp++; if (tx_level !== 4'd8) begin n_err++; $display("[TB] FAIL tx_full_level: got %0d expected 8", tx_level); end
    tx_wdata = 32'h200; tx_wen = 1'b1; tx_ren = 1'b1;
    tick();
    tx_wen = 1'b0; tx_ren = 1'b0;
    n_cmp++; if (tx_level !== 4'd8 || tx_rdata !== 32'h101) begin n_err++; $display("[TB] FAIL tx_full_rw: got level %0d head %h expected 8 / 101", tx_level, tx_rdata); end
    for (int k = 0; k < 8; k++) begin
      exp = (k < 7) ? 32'h101 + k : 32'h200;
      n_cmp++; if (tx_rdata !== exp) begin n_err++; $display("[TB] FAIL tx_order_%0d: got %h expected %h", k, tx_rdata, exp); end
      tx_ren = 1'b1;
      tick();
      tx_ren = 1'b0;
    end
    n_cmp++; if ({tx_empty, tx_irq, tx_udf} !== 3'b110) begin n_err++; $display("[TB] FAIL tx_after_drain: got %b expected 110", {tx_empty, tx_irq, tx_udf}); end
    tx_ren = 1'b1;
    tick();
    tx_ren = 1'b0;
    n_cmp++; if (tx_udf !== 1'b1) begin n_err++; $display("[TB] FAIL tx_udf: got %b expected 1", tx_udf); end
    tx_clear = 1'b1;
    tick();
    tx_clear = 1'b0;
    n_cmp++; if ({tx_ovf, tx_udf} !== 2'b00) begin n_err++; $display("[TB] FAIL tx_clear_flags: got %b expected 00", {tx_ovf, tx_udf}); end
  endtask

  task automatic test_rx_pop_empty_push();
    datalen = 5'd7; dord = 1'b1;
    rx_wdata = 32'h5A; rx_wen = 1'b1; rx_ren = 1'b1;
    tick();
    rx_wen = 1'b0; rx_ren = 1'b0;
    n_cmp++; if ({rx_udf, rx_empty} !== 2'b10 || rx_level !== 4'd1) begin n_err++; $display("[TB] FAIL rx_pop_empty: got udf/empty %b level %0d expected 10 / 1", {rx_udf, rx_empty}, rx_level); end
    n_cmp++; if (rx_rdata !== 32'h5A) begin n_err++; $display("[TB] FAIL rx_pop_empty_data: got %h expected 5a", rx_rdata); end
    rx_clear = 1'b1;
    tick();
    rx_clear = 1'b0;
    n_cmp++; if ({rx_udf, rx_level} !== 5'b0_0000) begin n_err++; $display("[TB] FAIL rx_clear: got %b expected 00000", {rx_udf, rx_level}); end
  endtask

  task automatic test_rx_irq();
    logic exp_irq;
    rx_thresh = 4'd3; datalen = 5'd7; dord = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rx_wdata = 32'h10 + k; rx_wen = 1'b1;
      tick();
      rx_wen = 1'b0;
      exp_irq = (k == 2);
      n_cmp++; if (rx_irq !== exp_irq || rx_level !== 4'(k + 1)) begin n_err++; $display("[TB] FAIL rx_irq_fill_%0d: got irq %b level %0d expected %b / %0d", k, rx_irq, rx_level, exp_irq, k + 1); end
    end
    rx_ren = 1'b1;
    tick();
    rx_ren = 1'b0;
    n_cmp++; if (rx_irq !== 1'b0 || rx_level !== 4'd2) begin n_err++; $display("[TB] FAIL rx_irq_fall: got irq %b level %0d expected 0 / 2", rx_irq, rx_level); end
    rx_thresh = 4'd0;
    for (int k = 0; k < 6; k++) begin
      rx_wdata = 32'h20 + k; rx_wen = 1'b1;
      tick();
    end
    rx_wen = 1'b0;
    n_cmp++; if ({rx_irq, rx_full} !== 2'b01) begin n_err++; $display("[TB] FAIL rx_irq_thresh0: got %b expected 01", {rx_irq, rx_full}); end
    rx_clear = 1'b1;
    tick();
    rx_clear = 1'b0; rx_thresh = 4'd3;
  endtask

  task automatic test_clear_priority();
    datalen = 5'd31; dord = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tx_wdata = 32'h300 + k; tx_wen = 1'b1;
      tick();
    end
    tx_wen = 1'b0; tx_ren = 1'b1;
    tick(); tick(); tick();
    tx_ren = 1'b0;
    n_cmp++; if (tx_level !== 4'd5 || tx_ovf !== 1'b1) begin n_err++; $display("[TB] FAIL clr_setup: got level %0d ovf %b expected 5 / 1", tx_level, tx_ovf); end
    tx_clear = 1'b1; tx_wen = 1'b1; tx_wdata = 32'hDEAD;
    tick();
    tx_clear = 1'b0; tx_wen = 1'b0;
    n_cmp++; if ({tx_empty, tx_ovf} !== 2'b10 || tx_level !== 4'd0 || tx_rdata !== 32'd0) begin n_err++; $display("[TB] FAIL clr_priority: got empty/ovf %b level %0d data %h expected 10 / 0 / 0", {tx_empty, tx_ovf}, tx_level, tx_rdata); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) begin
      tx_wdata = 32'h40 + k; tx_wen = 1'b1;
      rx_wdata = 32'h50 + k; rx_wen = 1'b1;
      tick();
    end
    tx_wen = 1'b0; rx_wen = 1'b0;
    n_cmp++; if ({tx_irq, rx_irq} !== 2'b01) begin n_err++; $display("[TB] FAIL mid_setup_irq: got %b expected 01", {tx_irq, rx_irq}); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if ({tx_level, rx_level} !== 8'd0 || {tx_empty, rx_empty} !== 2'b11) begin n_err++; $display("[TB] FAIL mid_reset_levels: got %h / %b expected 00 / 11", {tx_level, rx_level}, {tx_empty, rx_empty}); end
    n_cmp++; if ({tx_irq, rx_irq, tx_ovf, rx_ovf, tx_udf, rx_udf} !== 6'd0 || {tx_rdata, rx_rdata} !== 64'd0) begin n_err++; $display("[TB] FAIL mid_reset_outputs: got %b / %h expected 0 / 0", {tx_irq, rx_irq, tx_ovf, rx_ovf, tx_udf, rx_udf}, {tx_rdata, rx_rdata}); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (tx_irq !== 1'b1 || rx_level !== 4'd0) begin n_err++; $display("[TB] FAIL mid_release: got irq %b rx_level %0d expected 1 / 0", tx_irq, rx_level); end
  endtask

  initial begin
    rst_n = 1'b0; datalen = 5'd7; dord = 1'b1; rx_sext = 1'b0;
    tx_wdata = '0; rx_wdata = '0;
    tx_wen = 1'b0; tx_ren = 1'b0; rx_wen = 1'b0; rx_ren = 1'b0;
    tx_clear = 1'b0; rx_clear = 1'b0;
    tx_thresh = 4'd2; rx_thresh = 4'd3;
    test_reset();
    test_tx_norm();
    test_rx_norm();
    test_tx_overflow();
    test_rx_pop_empty_push();
    test_rx_irq();
    test_clear_priority();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spi_data_path.md
# spi_data_path

Parametrised data path between the SPI register/APB side and the SPI shift engine: a transmit FIFO and a receive FIFO, each with programmable frame length (1..DATA_WIDTH bits), bit-order normalisation and threshold interrupts. It is the next generation of the SPI data block: it adds parametrised width and depth, fill levels, programmable watermarks, sticky overflow/underflow flags and optional receive sign extension. It sits between the SPI register block (write/read data, control fields) and the SPI shifter, which always shifts frame bit `datalen` first.

## Interface
- DATA_WIDTH, 32, frame container width; 8..64.
- FIFO_DEPTH, 8, entries per FIFO; power of two, 2..64.
- LW = $clog2(DATA_WIDTH) (derived), width of `datalen`.
- PW = $clog2(FIFO_DEPTH)+1 (derived), width of levels and thresholds.

- clk  in  1  clock; one clock domain only.
- rst_n  in  1  synchronous, active-low reset.
- datalen  in  LW  frame length minus 1; 7 means 8-bit frames.
- dord  in  1  1 = MSB-first, 0 = LSB-first.
- rx_sext  in  1  sign-extend received frames (see Configuration).
- tx_wdata / tx_wen  in  DATA_WIDTH / 1  register-side write into TX FIFO.
- tx_ren  in  1  shifter pops TX head.
- tx_rdata  out  DATA_WIDTH  TX head, normalised.
- rx_wdata / rx_wen  in  DATA_WIDTH / 1  shifter pushes a received frame, right-aligned, first bit at [datalen].
- rx_ren  in  1  register-side pop of RX head.
- rx_rdata  out  DATA_WIDTH  RX head after de-normalisation.
- tx_clear, rx_clear  in  1  synchronous flush.
- tx_thresh, rx_thresh  in  PW  watermarks.
- tx_level, rx_level  out  PW  current fill.
- tx_full, tx_empty, rx_full, rx_empty  out  1  status.
- tx_irq, rx_irq  out  1  watermark interrupts, registered.
- tx_ovf, rx_ovf, tx_udf, rx_udf  out  1  sticky error flags.

## Operation
- TX normalisation happens at write. The stored word is `tx_wdata[datalen:0]` if dord=1. If dord=0, it is the bit-reverse within the field: stored[i] = tx_wdata[datalen-i]. Bits above datalen are stored as 0.
- RX de-normalisation happens at the output and is combinational on the current datalen/dord. Bits [datalen:0] of the head pass through unchanged if dord=1, or are reversed within the field if dord=0. Bits above datalen are 0, or a copy of result bit [datalen] when sign extension is active.
- Both FIFOs are first-word-fall-through. The `*_rdata` output shows the head whenever the FIFO is not empty, and is 0 when it is empty.
- Write when full with no same-cycle read: data is dropped, level unchanged, `*_ovf` set.
- Write when full with a same-cycle read: both are accepted, level unchanged.
- Read when empty: ignored and `*_udf` set. If a same-cycle write occurs, the write is still accepted and the level becomes 1.
- Pointers wrap modulo FIFO_DEPTH. Full means level == FIFO_DEPTH.
- Clear takes priority over read and write in the same cycle. It zeroes the pointers, the level and that FIFO's ovf/udf flags.
- tx_irq is set when `tx_level <= tx_thresh`. rx_irq is set when `rx_level >= rx_thresh` and `rx_thresh != 0`.
- Sticky flags are cleared only by reset or by the matching clear.

## Timing
- Reset (rst_n=0 at a clk edge) sets levels to 0, empty=1, full=0, all irq and sticky flags to 0, and rdata to 0.
- A write is visible on `*_rdata` and `*_level` on the cycle after the write edge.
- A read advances the head on the cycle after the read edge.
- irq outputs are registered from the next-state level, so they change in the same cycle as the level they reflect. After reset release with empty FIFOs, tx_irq rises one cycle later; it stays 0 while reset is held.
- Flags are set on the cycle following the offending request.
- Reset mid-transfer discards all contents. No partial frame is retained.

## Configuration
- `SPI_DATA_RX_SEXT_EN` defined: `rx_sext`=1 replicates result bit [datalen] into bits [DATA_WIDTH-1:datalen+1] of rx_rdata.
- `SPI_DATA_RX_SEXT_EN` undefined: `rx_sext` is ignored, upper bits are always 0, and no extension logic is built.

## Test plan
- datalen=7, dord=0, write tx_wdata=0x0000_01B1 -> tx_rdata=0x0000_008D. With dord=1, the same write gives 0x0000_00B1.
- RX push 0x0000_00C5 with datalen=7 -> dord=1 gives rx_rdata=0x0000_00C5 and dord=0 gives 0x0000_00A3. With the macro defined, rx_sext=1 and dord=1, the same push gives 0xFFFF_FFC5.
- Write 9 words into an 8-deep TX -> tx_full=1, tx_level=8, tx_ovf=1, and word 9 is absent. Then write and read in the same cycle while full -> level stays 8 and the data order is preserved.
- Pop an empty RX while rx_wen=1 in the same cycle -> rx_udf=1, rx_level=1, and the pushed data appears on rx_rdata.
- rx_thresh=3: push 3 frames -> rx_irq rises with rx_level=3. Pop 1 -> rx_irq falls. rx_thresh=0 -> rx_irq stays 0 regardless of level.
- With 5 entries and tx_ovf=1, assert tx_clear together with tx_wen -> next cycle tx_level=0, tx_empty=1, tx_ovf=0. Assert rst_n=0 mid-stream -> all outputs return to their reset values on the next edge.
